// File: rtl/run_event_logger.sv
// Run-length event logger: measures runs of the upstream "two or more ones" level and queues them in a small FIFO.
// Optional RUN_LOG_TIMESTAMP_EN adds a 16-bit free-running cycle counter and a per-event evt_ts output.
module run_event_logger #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out1_i,
    input  logic             out2_i,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [LEN_W-1:0] evt_len,
    output logic             evt_sat,
    output logic             overflow,
    output logic             input_err
`ifdef RUN_LOG_TIMESTAMP_EN
    ,
    output logic [15:0]      evt_ts
`endif
);

    // state | meaning
    // IDLE  | no run in progress
    // RUN   | counting consecutive cycles of effective out2
    typedef enum logic {IDLE, RUN} state_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   mem_len_q [DEPTH];
    logic [LEN_W-1:0]   mem_len_d [DEPTH];
    logic               mem_sat_q [DEPTH];
    logic               mem_sat_d [DEPTH];
    logic               overflow_q, overflow_d;
    logic               input_err_q, input_err_d;
    logic               out2_eff, push, pop, push_ok, empty, full;
    logic [PTR_W-1:0]   rd_idx, wr_idx;

`ifdef RUN_LOG_TIMESTAMP_EN
    logic [15:0]        ts_q, ts_d, run_ts_q, run_ts_d;
    logic [15:0]        mem_ts_q [DEPTH];
    logic [15:0]        mem_ts_d [DEPTH];
`endif

    // Both inputs high is illegal upstream; treat it as a run terminator.
    assign out2_eff = out2_i & ~out1_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (out2_eff) begin
                    state_d = RUN;
                    cnt_d   = LEN_W'(1);
                end
            end
            RUN: begin
                if (out2_eff) begin
                    if (cnt_q != LEN_MAX) cnt_d = cnt_q + LEN_W'(1);
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_idx  = rd_ptr_q[PTR_W-1:0];
    assign wr_idx  = wr_ptr_q[PTR_W-1:0];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    assign pop     = !empty && evt_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (PTR_W+1)'(push_ok);
        rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(pop);
        mem_len_d   = mem_len_q;
        mem_sat_d   = mem_sat_q;
        overflow_d  = overflow_q | (push && full && !pop);
        input_err_d = input_err_q | (out1_i & out2_i);
        if (push_ok) begin
            mem_len_d[wr_idx] = cnt_q;
            mem_sat_d[wr_idx] = (cnt_q == LEN_MAX);
        end
    end

`ifdef RUN_LOG_TIMESTAMP_EN
    always_comb begin
        ts_d     = ts_q + 16'd1;
        run_ts_d = run_ts_q;
        mem_ts_d = mem_ts_q;
        if (state_q == IDLE && out2_eff) run_ts_d = ts_q;
        if (push_ok) mem_ts_d[wr_idx] = run_ts_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q     <= '0;
            run_ts_q <= '0;
            mem_ts_q <= '{default: '0};
        end else begin
            ts_q     <= ts_d;
            run_ts_q <= run_ts_d;
            mem_ts_q <= mem_ts_d;
        end
    end

    assign evt_ts = empty ? 16'd0 : mem_ts_q[rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_len_q   <= '{default: '0};
            mem_sat_q   <= '{default: 1'b0};
            overflow_q  <= 1'b0;
            input_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_len_q   <= mem_len_d;
            mem_sat_q   <= mem_sat_d;
            overflow_q  <= overflow_d;
            input_err_q <= input_err_d;
        end
    end

    assign evt_valid = !empty;
    assign evt_len   = empty ? '0 : mem_len_q[rd_idx];
    assign evt_sat   = empty ? 1'b0 : mem_sat_q[rd_idx];
    assign overflow  = overflow_q;
    assign input_err = input_err_q;

endmodule

// File: tb/tb_run_event_logger.sv
// Directed self-checking bench for run_event_logger (DEPTH=4, LEN_W=8).
// Define RUN_LOG_TIMESTAMP_EN on both files to also exercise evt_ts.
module tb_run_event_logger;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       out1_i = 1'b0;
    logic       out2_i = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_len;
    logic       evt_sat;
    logic       overflow;
    logic       input_err;
`ifdef RUN_LOG_TIMESTAMP_EN
    logic [15:0] evt_ts;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    run_event_logger #(.DEPTH(4), .LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .out1_i    (out1_i),
        .out2_i    (out2_i),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_len   (evt_len),
        .evt_sat   (evt_sat),
        .overflow  (overflow),
        .input_err (input_err)
`ifdef RUN_LOG_TIMESTAMP_EN
        ,
        .evt_ts    (evt_ts)
`endif
    );

    // Outputs are sampled and inputs changed 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; out1_i = 1'b0; out2_i = 1'b0; evt_ready = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // One run of length len followed by the run-ending low cycle.
    task automatic run(input int len);
        out2_i = 1'b1;
        tick(len);
        out2_i = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", evt_valid); else passes++;
        checks++; if (evt_len !== 8'd0) $display("FAIL reset_len got %0d exp 0", evt_len); else passes++;
        checks++; if (evt_sat !== 1'b0) $display("FAIL reset_sat got %b exp 0", evt_sat); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passes++;
        checks++; if (input_err !== 1'b0) $display("FAIL reset_input_err got %b exp 0", input_err); else passes++;
    endtask

    task automatic test_single();
        do_reset();
        evt_ready = 1'b1;
        out2_i = 1'b1;
        tick(3);
        checks++; if (evt_valid !== 1'b0) $display("FAIL single_early_valid got %b exp 0", evt_valid); else passes++;
        out2_i = 1'b0;
        tick(1);
        checks++; if (evt_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", evt_valid); else passes++;
        checks++; if (evt_len !== 8'd3) $display("FAIL single_len got %0d exp 3", evt_len); else passes++;
        checks++; if (evt_sat !== 1'b0) $display("FAIL single_sat got %b exp 0", evt_sat); else passes++;
        tick(1);
        checks++; if (evt_valid !== 1'b0) $display("FAIL single_valid_drop got %b exp 0", evt_valid); else passes++;
        checks++; if (evt_len !== 8'd0) $display("FAIL single_len_idle got %0d exp 0", evt_len); else passes++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) run(2);
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_before got %b exp 0", overflow); else passes++;
        run(2);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else passes++;
        tick(2);
        checks++; if (evt_len !== 8'd2) $display("FAIL ovf_hold_len got %0d exp 2", evt_len); else passes++;
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (evt_valid !== 1'b1 || evt_len !== 8'd2)
                $display("FAIL ovf_drain%0d got valid=%b len=%0d exp valid=1 len=2", i, evt_valid, evt_len);
            else passes++;
            tick(1);
        end
        checks++; if (evt_valid !== 1'b0) $display("FAIL ovf_empty got %b exp 0", evt_valid); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else passes++;
    endtask

    task automatic test_saturation();
        do_reset();
        run(254);
        checks++; if (evt_len !== 8'd254 || evt_sat !== 1'b0)
            $display("FAIL sat_254 got len=%0d sat=%b exp len=254 sat=0", evt_len, evt_sat);
        else passes++;
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        run(255);
        checks++; if (evt_len !== 8'd255 || evt_sat !== 1'b1)
            $display("FAIL sat_255 got len=%0d sat=%b exp len=255 sat=1", evt_len, evt_sat);
        else passes++;
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        run(300);
        checks++; if (evt_len !== 8'd255 || evt_sat !== 1'b1)
            $display("FAIL sat_300 got len=%0d sat=%b exp len=255 sat=1", evt_len, evt_sat);
        else passes++;
    endtask

    task automatic test_full_pop();
        int exp_len;
        do_reset();
        for (int l = 1; l <= 4; l++) run(l);
        checks++; if (evt_len !== 8'd1) $display("FAIL full_head got %0d exp 1", evt_len); else passes++;
        out2_i = 1'b1;
        tick(5);
        out2_i = 1'b0;
        evt_ready = 1'b1;
        tick(1);
        checks++; if (overflow !== 1'b0) $display("FAIL full_pop_overflow got %b exp 0", overflow); else passes++;
        for (int i = 0; i < 4; i++) begin
            exp_len = i + 2;
            checks++; if (evt_valid !== 1'b1 || evt_len !== 8'(exp_len))
                $display("FAIL full_pop_order%0d got valid=%b len=%0d exp valid=1 len=%0d", i, evt_valid, evt_len, exp_len);
            else passes++;
            tick(1);
        end
        checks++; if (evt_valid !== 1'b0) $display("FAIL full_pop_empty got %b exp 0", evt_valid); else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run(3);
        out2_i = 1'b1;
        tick(1);
        out2_i = 1'b0;
        evt_ready = 1'b1;
        tick(1);
        checks++; if (evt_valid !== 1'b1 || evt_len !== 8'd1)
            $display("FAIL b2b_one_entry got valid=%b len=%0d exp valid=1 len=1", evt_valid, evt_len);
        else passes++;
        tick(1);
        checks++; if (evt_valid !== 1'b0) $display("FAIL b2b_empty got %b exp 0", evt_valid); else passes++;
    endtask

    task automatic test_input_err();
        do_reset();
        evt_ready = 1'b1;
        out1_i = 1'b1;
        tick(4);
        out1_i = 1'b0;
        tick(1);
        checks++; if (evt_valid !== 1'b0) $display("FAIL out1_only_valid got %b exp 0", evt_valid); else passes++;
        out2_i = 1'b1;
        tick(2);
        out1_i = 1'b1;
        tick(1);
        out1_i = 1'b0; out2_i = 1'b0;
        checks++; if (input_err !== 1'b1) $display("FAIL err_set got %b exp 1", input_err); else passes++;
        checks++; if (evt_valid !== 1'b1 || evt_len !== 8'd2)
            $display("FAIL err_event got valid=%b len=%0d exp valid=1 len=2", evt_valid, evt_len);
        else passes++;
        tick(1);
        out2_i = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0; out2_i = 1'b0;
        tick(2);
        checks++; if (evt_valid !== 1'b0 || evt_len !== 8'd0 || evt_sat !== 1'b0 || overflow !== 1'b0 || input_err !== 1'b0)
            $display("FAIL midrun_reset got valid=%b len=%0d sat=%b ovf=%b err=%b exp all 0",
                     evt_valid, evt_len, evt_sat, overflow, input_err);
        else passes++;
    endtask

`ifdef RUN_LOG_TIMESTAMP_EN
    task automatic test_timestamp();
        reset = 1'b1; out1_i = 1'b0; out2_i = 1'b0; evt_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(10);
        run(2);
        checks++; if (evt_ts !== 16'd10) $display("FAIL ts_value got %0d exp 10", evt_ts); else passes++;
        evt_ready = 1'b1;
        tick(1);
        checks++; if (evt_ts !== 16'd0) $display("FAIL ts_idle got %0d exp 0", evt_ts); else passes++;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_saturation();
        test_full_pop();
        test_back_to_back();
        test_input_err();
`ifdef RUN_LOG_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
